// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture front end.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_e;

  localparam int CAM_WORDS_MAX = 2048;
  localparam int CAM_LANES     = 4;

endpackage

// File: rtl/cam_sync2.sv
// Two-flop level synchronizer into the PCLKI domain, cleared by reset.
module cam_sync2 (
  input  logic PCLKI,
  input  logic WBs_RST_i,
  input  logic din,
  output logic dout
);

  logic meta_r;

  // Shift the asynchronous level through two flops
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      meta_r <= 1'b0;
      dout   <= 1'b0;
    end else begin
      meta_r <= din;
      dout   <= meta_r;
    end
  end

endmodule

// File: rtl/cam_pixel_packer.sv
// Single-shot camera frame capture: packs bytes into 32-bit words for the frame buffer.
// Optional test-pattern byte source compiled in with CAM_PACK_TEST_PATTERN_EN.
module cam_pixel_packer
  import cam_pkg::*;
#(
  parameter int WORDS_MAX = CAM_WORDS_MAX,
  parameter int ADR_W     = 11
) (
  input  logic             PCLKI,
  input  logic             WBs_RST_i,
  input  logic             VSYNCI,
  input  logic             HREFI,
  input  logic [7:0]       CAM_DAT_i,
  input  logic             cap_arm_i,
  input  logic             test_mode_i,
  output logic [31:0]      pack_dat_o,
  output logic [ADR_W-1:0] pack_adr_o,
  output logic             pack_vld_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic [ADR_W:0]   words_o,
  output logic             ovf_o,
  output logic             partial_o
);

  localparam logic [ADR_W:0] WMAX_C      = (ADR_W+1)'(WORDS_MAX);
  localparam logic [ADR_W:0] ONE_C       = (ADR_W+1)'(1);
  localparam logic [1:0]     LANE_LAST_C = 2'(CAM_LANES - 1);

  cam_state_e       state_r, state_n_s;
  logic             arm_s;
  logic             vs1_r, vs2_r, href1_r, href2_r;
  logic [7:0]       dat1_r, byte_s;
  logic             byte_valid_s, vs_rise_s, vs_fall_s, href_fall_s;
  logic [1:0]       lane_r, lane_n_s;
  logic [23:0]      word_r, word_n_s;
  logic             fin_pend_r, fin_n_s;
  logic             emit_s;
  logic [31:0]      emit_dat_s, dat_n_s;
  logic [ADR_W-1:0] adr_n_s;
  logic [ADR_W:0]   words_n_s;
  logic             vld_n_s, done_n_s, ovf_n_s, part_n_s;

  cam_sync2 u_arm_sync (
    .PCLKI     (PCLKI),
    .WBs_RST_i (WBs_RST_i),
    .din       (cap_arm_i),
    .dout      (arm_s)
  );

  // S1 input register plus one extra stage of the strobes for edge detection
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      vs1_r   <= 1'b0;
      vs2_r   <= 1'b0;
      href1_r <= 1'b0;
      href2_r <= 1'b0;
      dat1_r  <= 8'd0;
    end else begin
      vs1_r   <= VSYNCI;
      vs2_r   <= vs1_r;
      href1_r <= HREFI;
      href2_r <= href1_r;
      dat1_r  <= CAM_DAT_i;
    end
  end

  assign byte_valid_s = href1_r & vs1_r;
  assign vs_rise_s    = vs1_r & ~vs2_r;
  assign vs_fall_s    = ~vs1_r & vs2_r;
  assign href_fall_s  = ~href1_r & href2_r;

`ifdef CAM_PACK_TEST_PATTERN_EN
  logic [7:0] tp_cnt_r;

  // Test-pattern byte counter, restarted at each captured frame
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      tp_cnt_r <= 8'd0;
    end else if (state_r == ST_WAIT_VS && vs_rise_s) begin
      tp_cnt_r <= byte_valid_s ? 8'd1 : 8'd0;
    end else if (state_r == ST_CAPTURE && byte_valid_s) begin
      tp_cnt_r <= tp_cnt_r + 8'd1;
    end else begin
      tp_cnt_r <= tp_cnt_r;
    end
  end

  assign byte_s = test_mode_i ? tp_cnt_r : dat1_r;
`else
  logic unused_test_mode_s;
  assign unused_test_mode_s = test_mode_i;
  assign byte_s = dat1_r;
`endif

  // Next-state, lane packing and emit/count decisions
  always_comb begin
    state_n_s  = state_r;
    lane_n_s   = lane_r;
    word_n_s   = word_r;
    fin_n_s    = 1'b0;
    emit_s     = 1'b0;
    emit_dat_s = 32'd0;
    dat_n_s    = pack_dat_o;
    adr_n_s    = pack_adr_o;
    vld_n_s    = 1'b0;
    done_n_s   = 1'b0;
    words_n_s  = words_o;
    ovf_n_s    = ovf_o;
    part_n_s   = partial_o;
    case (state_r)
      ST_IDLE: begin
        if (arm_s) state_n_s = ST_WAIT_VS;
        else       state_n_s = ST_IDLE;
      end
      ST_WAIT_VS: begin
        if (!arm_s) begin
          state_n_s = ST_IDLE;
        end else if (vs_rise_s) begin
          state_n_s = ST_CAPTURE;
          words_n_s = '0;
          ovf_n_s   = 1'b0;
          part_n_s  = 1'b0;
          // a byte may already be valid on the first frame cycle
          word_n_s  = {16'd0, byte_s};
          lane_n_s  = byte_valid_s ? 2'd1 : 2'd0;
        end else begin
          state_n_s = ST_WAIT_VS;
        end
      end
      ST_CAPTURE: begin
        if (!arm_s) begin
          state_n_s = ST_IDLE;
          lane_n_s  = 2'd0;
        end else if (fin_pend_r) begin
          done_n_s  = 1'b1;
          state_n_s = ST_DONE;
        end else if (byte_valid_s) begin
          case (lane_r)
            2'd0:    word_n_s[7:0]   = byte_s;
            2'd1:    word_n_s[15:8]  = byte_s;
            2'd2:    word_n_s[23:16] = byte_s;
            default: begin
              emit_s     = 1'b1;
              emit_dat_s = {byte_s, word_r};
            end
          endcase
          lane_n_s = (lane_r == LANE_LAST_C) ? 2'd0 : lane_r + 2'd1;
        end else if ((href_fall_s || vs_fall_s) && lane_r != 2'd0) begin
          emit_s   = 1'b1;
          part_n_s = 1'b1;
          lane_n_s = 2'd0;
          fin_n_s  = vs_fall_s;
          case (lane_r)
            2'd1:    emit_dat_s = {24'd0, word_r[7:0]};
            2'd2:    emit_dat_s = {16'd0, word_r[15:0]};
            default: emit_dat_s = {8'd0, word_r};
          endcase
        end else if (vs_fall_s) begin
          done_n_s  = 1'b1;
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (!arm_s) state_n_s = ST_IDLE;
        else        state_n_s = ST_DONE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
    if (emit_s) begin
      if (words_o == WMAX_C) begin
        ovf_n_s = 1'b1;
      end else begin
        vld_n_s   = 1'b1;
        dat_n_s   = emit_dat_s;
        adr_n_s   = words_o[ADR_W-1:0];
        words_n_s = words_o + ONE_C;
      end
    end else begin
      vld_n_s = 1'b0;
    end
  end

  // State, packing registers and registered outputs
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_r      <= ST_IDLE;
      lane_r       <= 2'd0;
      word_r       <= 24'd0;
      fin_pend_r   <= 1'b0;
      pack_dat_o   <= 32'd0;
      pack_adr_o   <= '0;
      pack_vld_o   <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      words_o      <= '0;
      ovf_o        <= 1'b0;
      partial_o    <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      lane_r       <= lane_n_s;
      word_r       <= word_n_s;
      fin_pend_r   <= fin_n_s;
      pack_dat_o   <= dat_n_s;
      pack_adr_o   <= adr_n_s;
      pack_vld_o   <= vld_n_s;
      frame_done_o <= done_n_s;
      busy_o       <= (state_n_s == ST_WAIT_VS) || (state_n_s == ST_CAPTURE);
      words_o      <= words_n_s;
      ovf_o        <= ovf_n_s;
      partial_o    <= part_n_s;
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed scoreboard bench for cam_pixel_packer.
module tb_cam_pixel_packer;

  logic        PCLKI = 1'b0;
  logic        WBs_RST_i = 1'b1;
  logic        VSYNCI = 1'b0;
  logic        HREFI = 1'b0;
  logic [7:0]  CAM_DAT_i = 8'd0;
  logic        cap_arm_i = 1'b0;
  logic        test_mode_i = 1'b0;
  logic [31:0] pack_dat_o;
  logic [10:0] pack_adr_o;
  logic        pack_vld_o;
  logic        frame_done_o;
  logic        busy_o;
  logic [11:0] words_o;
  logic        ovf_o;
  logic        partial_o;

  cam_pixel_packer dut (
    .PCLKI        (PCLKI),
    .WBs_RST_i    (WBs_RST_i),
    .VSYNCI       (VSYNCI),
    .HREFI        (HREFI),
    .CAM_DAT_i    (CAM_DAT_i),
    .cap_arm_i    (cap_arm_i),
    .test_mode_i  (test_mode_i),
    .pack_dat_o   (pack_dat_o),
    .pack_adr_o   (pack_adr_o),
    .pack_vld_o   (pack_vld_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .words_o      (words_o),
    .ovf_o        (ovf_o),
    .partial_o    (partial_o)
  );

  always #5 PCLKI = ~PCLKI;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [42:0] sb[$];

  int n_vld = 0, n_done = 0;
  int first_vld_cyc = -1, last_vld_cyc = -1, done_cyc = -1;
  logic [10:0] last_adr = 11'd0;

  int m_lane, m_words, m_nbytes, t4_edge;
  logic [31:0] m_word;
  bit m_ovf, m_part, tp_on;
  logic [7:0] m_tp;

  always @(posedge PCLKI) cyc_cnt <= cyc_cnt + 1;

  // Output monitor: every strobe is popped from the scoreboard and compared
  always @(negedge PCLKI) begin
    if (pack_vld_o) begin
      if (n_vld == 0) first_vld_cyc = cyc_cnt;
      n_vld++;
      last_vld_cyc = cyc_cnt;
      last_adr = pack_adr_o;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_strobe: observed adr=0x%0h dat=0x%0h expected no strobe", pack_adr_o, pack_dat_o);
      end
      if (sb.size() > 0) begin
        logic [42:0] exp_w;
        exp_w = sb.pop_front();
        checks++;
        assert ({pack_adr_o, pack_dat_o} === exp_w) else begin
          errors++;
          $error("FAIL strobe_word: observed adr=0x%0h dat=0x%0h expected adr=0x%0h dat=0x%0h",
                 pack_adr_o, pack_dat_o, exp_w[42:32], exp_w[31:0]);
        end
      end
    end
    if (frame_done_o) begin
      n_done++;
      done_cyc = cyc_cnt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge PCLKI);
    #1;
  endtask

  task automatic model_start();
    m_lane = 0; m_word = 32'd0; m_words = 0; m_nbytes = 0;
    m_ovf = 1'b0; m_part = 1'b0; m_tp = 8'd0;
  endtask

  task automatic model_emit();
    if (m_words == 2048) m_ovf = 1'b1;
    else begin
      sb.push_back({11'(m_words), m_word});
      m_words++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] v;
    v = tp_on ? m_tp : b;
    m_tp = m_tp + 8'd1;
    if (m_nbytes == 3) t4_edge = cyc_cnt + 1;
    m_nbytes++;
    m_word[8*m_lane +: 8] = v;
    if (m_lane == 3) begin
      model_emit();
      m_lane = 0;
      m_word = 32'd0;
    end else m_lane++;
  endtask

  task automatic model_flush();
    if (m_lane != 0) begin
      model_emit();
      m_part = 1'b1;
      m_lane = 0;
      m_word = 32'd0;
    end
  endtask

  task automatic drive_line(input int n, input logic [7:0] base, input bit cap);
    for (int i = 0; i < n; i++) begin
      step();
      HREFI = 1'b1;
      CAM_DAT_i = base + 8'(i);
      if (cap) model_byte(base + 8'(i));
    end
  endtask

  // tail = 0 drops VSYNC together with the final HREF fall
  task automatic frame(input int nlines, input int nbytes, input logic [7:0] base, input bit cap, input int tail);
    if (cap) model_start();
    step(); VSYNCI = 1'b1; HREFI = 1'b0;
    repeat (3) step();
    for (int l = 0; l < nlines; l++) begin
      drive_line(nbytes, base, cap);
      step(); HREFI = 1'b0; CAM_DAT_i = 8'd0;
      if (cap) model_flush();
      if (l == nlines - 1 && tail == 0) VSYNCI = 1'b0;
      else repeat (4) step();
    end
    if (tail > 0) begin
      repeat (tail) step();
      VSYNCI = 1'b0;
    end
    repeat (6) step();
  endtask

  task automatic rearm();
    cap_arm_i = 1'b0;
    repeat (5) step();
    cap_arm_i = 1'b1;
    repeat (5) step();
  endtask

  initial begin
    int nv0, nd0;
    tp_on = 1'b0;
    #1;
    chk("reset_dat", pack_dat_o, 32'd0);
    chk("reset_adr", 32'(pack_adr_o), 32'd0);
    chk("reset_words", 32'(words_o), 32'd0);
    chk("reset_flags", 32'({pack_vld_o, frame_done_o, busy_o, ovf_o, partial_o}), 32'd0);
    repeat (3) step();
    WBs_RST_i = 1'b0;
    repeat (3) step();

    // two lines of 16 bytes
    cap_arm_i = 1'b1;
    repeat (5) step();
    chk("busy_wait_vs", 32'(busy_o), 32'd1);
    nv0 = n_vld; nd0 = n_done;
    frame(2, 16, 8'h10, 1'b1, 3);
    chk("t1_strobes", 32'(n_vld - nv0), 32'd8);
    chk("t1_done_pulses", 32'(n_done - nd0), 32'd1);
    chk("t1_words", 32'(words_o), 32'd8);
    chk("t1_ovf", 32'(ovf_o), 32'd0);
    chk("t1_partial", 32'(partial_o), 32'd0);
    chk("t1_latency", 32'(first_vld_cyc), 32'(t4_edge + 1));
    chk("t1_busy_done", 32'(busy_o), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 6-byte line, HREF and VSYNC fall together
    rearm();
    nv0 = n_vld; nd0 = n_done;
    frame(1, 6, 8'hA0, 1'b1, 0);
    chk("t2_strobes", 32'(n_vld - nv0), 32'd2);
    chk("t2_done_pulses", 32'(n_done - nd0), 32'd1);
    chk("t2_done_after_flush", 32'(done_cyc), 32'(last_vld_cyc + 1));
    chk("t2_partial", 32'(partial_o), 32'd1);
    chk("t2_words", 32'(words_o), 32'd2);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 8200-byte frame overflows the buffer
    rearm();
    nv0 = n_vld; nd0 = n_done;
    frame(41, 200, 8'h00, 1'b1, 3);
    chk("t3_strobes", 32'(n_vld - nv0), 32'd2048);
    chk("t3_last_adr", 32'(last_adr), 32'h7FF);
    chk("t3_ovf", 32'(ovf_o), 32'd1);
    chk("t3_words", 32'(words_o), 32'd2048);
    chk("t3_model_ovf", 32'(m_ovf), 32'd1);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // armed while VSYNC already high: that frame is ignored
    cap_arm_i = 1'b0;
    repeat (5) step();
    nv0 = n_vld; nd0 = n_done;
    VSYNCI = 1'b1;
    repeat (2) step();
    cap_arm_i = 1'b1;
    repeat (6) step();
    drive_line(8, 8'h50, 1'b0);
    step(); HREFI = 1'b0;
    repeat (3) step();
    VSYNCI = 1'b0;
    repeat (3) step();
    chk("t4_no_strobe_mid_frame", 32'(n_vld - nv0), 32'd0);
    frame(1, 8, 8'h60, 1'b1, 3);
    chk("t4_strobes", 32'(n_vld - nv0), 32'd2);
    chk("t4_done_pulses", 32'(n_done - nd0), 32'd1);
    chk("t4_words", 32'(words_o), 32'd2);

    // abort by dropping arm after 5 words
    rearm();
    nv0 = n_vld; nd0 = n_done;
    model_start();
    step(); VSYNCI = 1'b1;
    repeat (3) step();
    drive_line(20, 8'hC0, 1'b1);
    step(); CAM_DAT_i = 8'hE0; cap_arm_i = 1'b0;
    step(); CAM_DAT_i = 8'hE1;
    step(); CAM_DAT_i = 8'hE2;
    step(); HREFI = 1'b0;
    repeat (3) step();
    VSYNCI = 1'b0;
    repeat (6) step();
    chk("t5_strobes", 32'(n_vld - nv0), 32'd5);
    chk("t5_no_done", 32'(n_done - nd0), 32'd0);
    chk("t5_words", 32'(words_o), 32'd5);
    chk("t5_busy", 32'(busy_o), 32'd0);

    // reset in the middle of a line
    cap_arm_i = 1'b1;
    repeat (5) step();
    model_start();
    step(); VSYNCI = 1'b1;
    repeat (3) step();
    drive_line(6, 8'h30, 1'b1);
    WBs_RST_i = 1'b1;
    #1;
    chk("t6_rst_dat", pack_dat_o, 32'd0);
    chk("t6_rst_words", 32'(words_o), 32'd0);
    chk("t6_rst_flags", 32'({pack_vld_o, frame_done_o, busy_o, ovf_o, partial_o, pack_adr_o}), 32'd0);
    sb.delete();
    nv0 = n_vld; nd0 = n_done;
    repeat (3) step();
    WBs_RST_i = 1'b0;
    drive_line(12, 8'h40, 1'b0);
    step(); HREFI = 1'b0;
    repeat (3) step();
    VSYNCI = 1'b0;
    repeat (6) step();
    chk("t6_no_strobe_after_rst", 32'(n_vld - nv0), 32'd0);
    chk("t6_no_done_after_rst", 32'(n_done - nd0), 32'd0);

    // test-mode frame (pattern only when the feature is compiled in)
    test_mode_i = 1'b1;
`ifdef CAM_PACK_TEST_PATTERN_EN
    tp_on = 1'b1;
`else
    tp_on = 1'b0;
`endif
    nv0 = n_vld; nd0 = n_done;
    frame(1, 8, 8'h77, 1'b1, 3);
    chk("t7_strobes", 32'(n_vld - nv0), 32'd2);
    chk("t7_done_pulses", 32'(n_done - nd0), 32'd1);
    chk("t7_sb_empty", 32'(sb.size()), 32'd0);
    test_mode_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
